mcpu_bus_unit: RTL and testbench

- Parametrised memory bus unit for the multicycle MIPS core.
- Replaces the core's direct drive of Addr_out/Data_out/mem_w with one sequenced access engine.
- Handles instruction fetch, byte/half/word loads and stores, the MIO_ready wait-state handshake, alignment checking and a bus timeout.
- Sits between the control FSM/datapath and the memory/IO bus.

---
 rtl/mcpu_bus_unit.sv | 187 ++++++++++++++++++
 tb/tb_mcpu_bus_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mcpu_bus_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mcpu_bus_unit
// Brief    : Sequenced memory/IO access engine for the multicycle MIPS core.
// Revision : 1.0 - initial release
// ============================================================================
module mcpu_bus_unit #(
  parameter int ADDR_W  = 32,
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic              fetch,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata,
  output logic [31:0]       inst,
  output logic              fault,
  output logic [1:0]        fault_code,
  output logic [1:0]        state,
  output logic              mem_req,
  output logic              mem_w,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] Addr_out,
  output logic [31:0]       Data_out,
  input  logic [31:0]       Data_in,
  input  logic              MIO_ready
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_ACCESS   = 2'b01,
    S_COMPLETE = 2'b10,
    S_FAULT    = 2'b11
  } state_t;

  localparam logic [TO_W-1:0] c_TO_LAST = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;

  state_t            r_state;
  state_t            w_next;
  logic              r_store;
  logic              r_fetch;
  logic [1:0]        r_size;
  logic              r_uns;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [TO_W-1:0]   r_cnt;
  logic [31:0]       r_rdata;
  logic [31:0]       r_inst;
  logic [1:0]        r_fcode;

  logic [1:0]        w_size_eff;
  logic              w_misalign;
  logic              w_timeout;
  logic [7:0]        w_lane_b;
  logic [15:0]       w_lane_h;
  logic [31:0]       w_ld;
  logic [3:0]        w_be;
  logic [31:0]       w_dout;

  // A fetch is always a word load regardless of the size/we inputs.
  assign w_size_eff = fetch ? 2'b10 : size;
  assign w_misalign = (w_size_eff == 2'b11)
                    | ((w_size_eff == 2'b01) & addr[0])
                    | ((w_size_eff == 2'b10) & (|addr[1:0]));
  assign w_timeout  = (TIMEOUT != 0) && (r_cnt == c_TO_LAST);

  assign w_lane_b = Data_in[{r_addr[1:0], 3'b000} +: 8];
  assign w_lane_h = Data_in[{r_addr[1], 4'b0000} +: 16];

  always_comb begin
    w_ld   = Data_in;
    w_be   = 4'b1111;
    w_dout = r_wdata;
    case (r_size)
      2'b00: begin
        w_ld   = {{24{~r_uns & w_lane_b[7]}}, w_lane_b};
        w_be   = 4'b0001 << r_addr[1:0];
        w_dout = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_ld   = {{16{~r_uns & w_lane_h[15]}}, w_lane_h};
        w_be   = 4'b0011 << {r_addr[1], 1'b0};
        w_dout = {2{r_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    busy       = 1'b0;
    done       = 1'b0;
    fault      = 1'b0;
    mem_req    = 1'b0;
    mem_w      = 1'b0;
    mem_be     = 4'b0000;
    Addr_out   = '0;
    Data_out   = 32'h0;
    case (r_state)
      S_IDLE: begin
        if (req) w_next = w_misalign ? S_FAULT : S_ACCESS;
      end
      S_ACCESS: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_w    = r_store;
        mem_be   = w_be;
        Addr_out = {r_addr[ADDR_W-1:2], 2'b00};
        Data_out = w_dout;
        // Ready wins over an expiring wait counter on the same edge.
        if (MIO_ready)      w_next = S_COMPLETE;
        else if (w_timeout) w_next = S_FAULT;
      end
      S_COMPLETE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        busy   = 1'b1;
        done   = 1'b1;
        fault  = 1'b1;
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_store <= 1'b0;
      r_fetch <= 1'b0;
      r_size  <= 2'b00;
      r_uns   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'h0;
      r_cnt   <= '0;
      r_rdata <= 32'h0;
      r_inst  <= 32'h0;
      r_fcode <= 2'b00;
    end else begin
      if (r_state == S_IDLE && req) begin
        r_store <= we & ~fetch;
        r_fetch <= fetch;
        r_size  <= w_size_eff;
        r_uns   <= unsigned_ld;
        r_addr  <= addr;
        r_wdata <= wdata;
        r_cnt   <= '0;
        if (w_misalign) r_fcode <= 2'b01;
      end
      if (r_state == S_ACCESS) begin
        if (MIO_ready) begin
          if (!r_store) r_rdata <= w_ld;
          if (r_fetch)  r_inst  <= w_ld;
          r_fcode <= 2'b00;
        end else if (TIMEOUT != 0) begin
          if (w_timeout) r_fcode <= 2'b10;
          else           r_cnt   <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign state      = r_state;
  assign rdata      = r_rdata;
  assign inst       = r_inst;
  assign fault_code = r_fcode;

endmodule
`default_nettype wire

// File: tb/tb_mcpu_bus_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mcpu_bus_unit
// Brief    : Self-checking bench for mcpu_bus_unit (table + random vectors).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mcpu_bus_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset, req, we, fetch, unsigned_ld, MIO_ready;
  logic [1:0]  size;
  logic [31:0] addr, wdata, Data_in;
  logic        busy, done, fault, mem_req, mem_w;
  logic [31:0] rdata, inst, Addr_out, Data_out;
  logic [1:0]  fault_code, state;
  logic [3:0]  mem_be;

  mcpu_bus_unit #(.ADDR_W(32), .TO_W(8), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .fetch(fetch), .size(size),
    .unsigned_ld(unsigned_ld), .addr(addr), .wdata(wdata), .busy(busy),
    .done(done), .rdata(rdata), .inst(inst), .fault(fault),
    .fault_code(fault_code), .state(state), .mem_req(mem_req), .mem_w(mem_w),
    .mem_be(mem_be), .Addr_out(Addr_out), .Data_out(Data_out),
    .Data_in(Data_in), .MIO_ready(MIO_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        fetch;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] din;
    int          delay;
    logic [1:0]  code;
    logic [3:0]  be;
    logic [31:0] dout;
    logic [31:0] ld;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] m_rdata = 32'h0;
  logic [31:0] m_inst = 32'h0;
  logic [1:0]  m_code = 2'b00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic w, input logic f, input logic [1:0] s,
                              input logic u, input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] di, input int dl, input logic [1:0] c,
                              input logic [3:0] b, input logic [31:0] dq, input logic [31:0] l);
    vec_t v;
    v.we = w; v.fetch = f; v.size = s; v.uns = u; v.addr = a; v.wdata = wd;
    v.din = di; v.delay = dl; v.code = c; v.be = b; v.dout = dq; v.ld = l;
    return v;
  endfunction

  // Reference: expected response derived from byte counts and plain arithmetic.
  function automatic vec_t model(input vec_t v);
    vec_t        r;
    int          es, nb, off;
    logic [31:0] mask, val;
    r   = v;
    es  = v.fetch ? 2 : int'(v.size);
    off = int'(v.addr % 4);
    if (es == 3 || (es == 1 && off % 2 != 0) || (es == 2 && off != 0)) r.code = 2'd1;
    else if (v.delay >= TO)                                             r.code = 2'd2;
    else                                                                r.code = 2'd0;
    nb   = (es == 3) ? 4 : (1 << es);
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
    r.be = 4'(((1 << nb) - 1) << off);
    if (nb == 1)      r.dout = (v.wdata & 32'hFF) * 32'h0101_0101;
    else if (nb == 2) r.dout = (v.wdata & 32'hFFFF) * 32'h0001_0001;
    else              r.dout = v.wdata;
    val = (v.din >> (8 * off)) & mask;
    if (!v.uns && nb < 4 && val[8 * nb - 1]) val = val | ~mask;
    r.ld = val;
    return r;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, ".state"}, 32'(state), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".fault"}, 32'(fault), 0);
    chk({tag, ".fault_code"}, 32'(fault_code), 0);
    chk({tag, ".rdata"}, rdata, 0);
    chk({tag, ".inst"}, inst, 0);
    chk({tag, ".mem_req"}, 32'(mem_req), 0);
    chk({tag, ".mem_w"}, 32'(mem_w), 0);
    chk({tag, ".mem_be"}, 32'(mem_be), 0);
    chk({tag, ".Addr_out"}, Addr_out, 0);
    chk({tag, ".Data_out"}, Data_out, 0);
  endtask

  // Entered and left at a negedge with the DUT idle.
  task automatic run(input vec_t v, input string tag);
    int k, exp_k;
    req = 1'b1; we = v.we; fetch = v.fetch; size = v.size; unsigned_ld = v.uns;
    addr = v.addr; wdata = v.wdata; Data_in = v.din; MIO_ready = 1'b0;
    @(negedge clk);
    // Keep req high with junk fields: a busy unit must ignore both.
    we = 1'($urandom); fetch = 1'($urandom); size = 2'($urandom);
    unsigned_ld = 1'($urandom); addr = $urandom; wdata = $urandom;
    exp_k = (v.code == 2'd1) ? 0 : (v.code == 2'd2) ? TO : v.delay + 1;
    k = 0;
    while (state == 2'b01 && k < 20) begin
      chk({tag, ".mem_req"}, 32'(mem_req), 1);
      chk({tag, ".mem_w"}, 32'(mem_w), 32'(v.we & ~v.fetch));
      chk({tag, ".mem_be"}, 32'(mem_be), 32'(v.be));
      chk({tag, ".Addr_out"}, Addr_out, v.addr & 32'hFFFF_FFFC);
      chk({tag, ".Data_out"}, Data_out, v.dout);
      chk({tag, ".acc_done"}, 32'(done), 0);
      MIO_ready = (k >= v.delay);
      Data_in   = MIO_ready ? v.din : $urandom;
      k++;
      @(negedge clk);
    end
    req = 1'b0; MIO_ready = 1'b0;
    chk({tag, ".access_cycles"}, 32'(k), 32'(exp_k));
    if (v.code == 2'd0 && !(v.we && !v.fetch)) m_rdata = v.ld;
    if (v.code == 2'd0 && v.fetch)             m_inst  = v.ld;
    m_code = v.code;
    chk({tag, ".state"}, 32'(state), (v.code != 2'd0) ? 3 : 2);
    chk({tag, ".done"}, 32'(done), 1);
    chk({tag, ".busy"}, 32'(busy), 1);
    chk({tag, ".fault"}, 32'(fault), 32'(v.code != 2'd0));
    chk({tag, ".fault_code"}, 32'(fault_code), 32'(m_code));
    chk({tag, ".end_mem_req"}, 32'(mem_req), 0);
    chk({tag, ".rdata"}, rdata, m_rdata);
    chk({tag, ".inst"}, inst, m_inst);
    @(negedge clk);
    chk({tag, ".idle_state"}, 32'(state), 0);
    chk({tag, ".idle_done"}, 32'(done), 0);
    chk({tag, ".idle_busy"}, 32'(busy), 0);
    chk({tag, ".held_code"}, 32'(fault_code), 32'(m_code));
    chk({tag, ".held_rdata"}, rdata, m_rdata);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[14];
    vec_t v;
    tbl[0]  = mk(0, 1, 2'b10, 0, 32'h40,  32'h0,         32'h2008_0005, 0, 2'd0, 4'hF, 32'h0,         32'h2008_0005);
    tbl[1]  = mk(0, 0, 2'b00, 0, 32'h103, 32'h0,         32'h80FF_1234, 0, 2'd0, 4'h8, 32'h0,         32'hFFFF_FF80);
    tbl[2]  = mk(0, 0, 2'b00, 1, 32'h103, 32'h0,         32'h80FF_1234, 0, 2'd0, 4'h8, 32'h0,         32'h0000_0080);
    tbl[3]  = mk(1, 0, 2'b01, 0, 32'h202, 32'h0000_BEEF, 32'h1111_2222, 3, 2'd0, 4'hC, 32'hBEEF_BEEF, 32'h0);
    tbl[4]  = mk(0, 0, 2'b10, 0, 32'h101, 32'h0,         32'h0,         0, 2'd1, 4'h0, 32'h0,         32'h0);
    tbl[5]  = mk(0, 0, 2'b11, 0, 32'h100, 32'h0,         32'h0,         0, 2'd1, 4'h0, 32'h0,         32'h0);
    tbl[6]  = mk(0, 0, 2'b10, 0, 32'h300, 32'h0,         32'h1234_5678, 9, 2'd2, 4'hF, 32'h0,         32'h0);
    tbl[7]  = mk(0, 0, 2'b10, 0, 32'h304, 32'hAAAA_5555, 32'hCAFE_F00D, 3, 2'd0, 4'hF, 32'hAAAA_5555, 32'hCAFE_F00D);
    tbl[8]  = mk(0, 0, 2'b01, 0, 32'h102, 32'h0,         32'h8001_7FFF, 1, 2'd0, 4'hC, 32'h0,         32'hFFFF_8001);
    tbl[9]  = mk(0, 0, 2'b01, 1, 32'h100, 32'h0,         32'h8001_7FFF, 0, 2'd0, 4'h3, 32'h0,         32'h0000_7FFF);
    tbl[10] = mk(1, 0, 2'b00, 0, 32'h11,  32'h1234_5678, 32'h0,         2, 2'd0, 4'h2, 32'h7878_7878, 32'h0);
    tbl[11] = mk(0, 0, 2'b01, 0, 32'h3,   32'h0,         32'h0,         0, 2'd1, 4'h0, 32'h0,         32'h0);
    tbl[12] = mk(1, 1, 2'b00, 0, 32'h44,  32'h0BAD_F00D, 32'h8C22_0004, 1, 2'd0, 4'hF, 32'h0BAD_F00D, 32'h8C22_0004);
    tbl[13] = mk(0, 1, 2'b00, 0, 32'h42,  32'h0,         32'h0,         0, 2'd1, 4'h0, 32'h0,         32'h0);

    reset = 1'b0; req = 1'b0; we = 1'b0; fetch = 1'b0; size = 2'b00;
    unsigned_ld = 1'b0; addr = 32'h0; wdata = 32'h0; Data_in = 32'h0; MIO_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) run(tbl[i], $sformatf("tbl%0d", i));

    // Reset in the middle of an access: abandoned without a done pulse.
    req = 1'b1; we = 1'b0; fetch = 1'b0; size = 2'b10; addr = 32'h500;
    Data_in = 32'h5555_AAAA; MIO_ready = 1'b0;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    chk("mid.state_before", 32'(state), 1);
    #2 reset = 1'b0;
    #1 chk_zero("midreset");
    m_rdata = 32'h0; m_inst = 32'h0; m_code = 2'b00;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("midreset.no_done", 32'(done), 0);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("postreset.done", 32'(done), 0);
    run(tbl[0], "postreset");

    for (int i = 0; i < 40; i++) begin
      v.we    = 1'($urandom);
      v.fetch = ($urandom_range(0, 3) == 0);
      v.size  = 2'($urandom);
      v.uns   = 1'($urandom);
      v.addr  = $urandom & 32'h0000_0FFF;
      if ($urandom_range(0, 1) == 1) v.addr[1:0] = 2'b00;
      v.wdata = $urandom;
      v.din   = $urandom;
      v.delay = $urandom_range(0, 5);
      v = model(v);
      run(v, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
